// File: rtl/switch_debounce_pkg.sv
// Shared types and constants for the switch/key debouncer.
package switch_debounce_pkg;

    // Per-channel FSM state: STABLE waits for a difference, CANDIDATE times it.
    typedef enum logic {
        ST_STABLE    = 1'b0,
        ST_CANDIDATE = 1'b1
    } dbc_state_e;

    // DE10-Nano board clock.
    localparam int unsigned CLK_HZ = 50_000_000;

    // 20 ms worth of board clock cycles, the default settle window.
    localparam int unsigned DEBOUNCE_20MS = CLK_HZ / 50;

endpackage : switch_debounce_pkg

// File: rtl/debounce_channel.sv
// Single-bit synchronizer plus debounce FSM with registered rise/fall pulses.
module debounce_channel
    import switch_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw_i,
    output logic sw_db_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value on the edge that completes a full stable run.
    localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;

    dbc_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // Metastability chain; only the last stage feeds the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw_i};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Next-state: time how long the synchronized level differs from the accepted one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (sync_s != db_q) begin
                    state_d = ST_CANDIDATE;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            ST_CANDIDATE: begin
                if (sync_s == db_q) begin
                    // Bounce: throw away the partial run.
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    db_d    = sync_s;
                    rise_d  = sync_s;
                    fall_d  = ~sync_s;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // FSM, counter, accepted level and edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            db_q    <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sw_db_o = db_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule : debounce_channel

// File: rtl/switch_debounce.sv
// Multi-channel switch/key synchronizer and debouncer; channels are independent.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] sw_raw_i,
    output logic [N_CH-1:0] sw_db_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .RESET_LEVEL     (RESET_LEVEL)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .sw_raw_i (sw_raw_i[i]),
            .sw_db_o  (sw_db_o[i]),
            .rise_o   (rise_o[i]),
            .fall_o   (fall_o[i])
        );
    end

endmodule : switch_debounce

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with an 8-cycle window and 2-stage sync.
module tb_switch_debounce;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw_raw;
    logic [3:0] sw_db;
    logic [3:0] rise;
    logic [3:0] fall;

    int vectors;
    int errors;
    int rise_cnt [4] = '{0, 0, 0, 0};
    int fall_cnt [4] = '{0, 0, 0, 0};
    int r;
    int f;

    switch_debounce #(
        .N_CH            (4),
        .DEBOUNCE_CYCLES (8),
        .SYNC_STAGES     (2),
        .RESET_LEVEL     (1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_raw_i (sw_raw),
        .sw_db_o  (sw_db),
        .rise_o   (rise),
        .fall_o   (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tallies, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rise[i]) rise_cnt[i] <= rise_cnt[i] + 1;
            if (fall[i]) fall_cnt[i] <= fall_cnt[i] + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkint(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst_n   = 1'b0;
        sw_raw  = 4'b1111;

        // Reset holds everything at RESET_LEVEL even with inputs high.
        step(3);
        check4("rst_db", sw_db, 4'b0000);
        check4("rst_rise", rise, 4'b0000);
        check4("rst_fall", fall, 4'b0000);
        sw_raw = 4'b0000;
        step(3);
        rst_n = 1'b1;
        step(3);
        check4("idle_db", sw_db, 4'b0000);

        // Clean step on ch0: accepted on the 10th edge.
        sw_raw = 4'b0001;
        step(9);
        check4("step_pre_db", sw_db, 4'b0000);
        step(1);
        check4("step_db", sw_db, 4'b0001);
        check4("step_rise", rise, 4'b0001);
        check4("step_fall", fall, 4'b0000);
        step(1);
        check4("step_rise_end", rise, 4'b0000);
        check4("step_db_hold", sw_db, 4'b0001);

        // ch1 high for 7 sampled cycles: rejected.
        r = rise_cnt[1];
        sw_raw = 4'b0011;
        step(7);
        sw_raw = 4'b0001;
        step(12);
        check4("glitch7_db", sw_db, 4'b0001);
        checkint("glitch7_pulses", rise_cnt[1] - r, 0);

        // ch1 held: accepted after the full window.
        sw_raw = 4'b0011;
        step(9);
        check4("hold8_pre_db", sw_db, 4'b0001);
        step(1);
        check4("hold8_db", sw_db, 4'b0011);
        check4("hold8_rise", rise, 4'b0010);
        step(3);
        checkint("hold8_pulses", rise_cnt[1] - r, 1);

        // ch2 bounces 1,0,1,0,1 then holds 1.
        r = rise_cnt[2];
        sw_raw = 4'b0111; step(1);
        sw_raw = 4'b0011; step(1);
        sw_raw = 4'b0111; step(1);
        sw_raw = 4'b0011; step(1);
        sw_raw = 4'b0111;
        step(9);
        check4("bounce_pre_db", sw_db, 4'b0011);
        checkint("bounce_pre_pulses", rise_cnt[2] - r, 0);
        step(1);
        check4("bounce_db", sw_db, 4'b0111);
        check4("bounce_rise", rise, 4'b0100);
        step(3);
        checkint("bounce_pulses", rise_cnt[2] - r, 1);

        // Release ch0 back to 0.
        f = fall_cnt[0];
        sw_raw = 4'b0110;
        step(9);
        check4("release_pre_db", sw_db, 4'b0111);
        step(1);
        check4("release_db", sw_db, 4'b0110);
        check4("release_fall", fall, 4'b0001);
        check4("release_rise", rise, 4'b0000);
        step(1);
        check4("release_fall_end", fall, 4'b0000);
        step(2);
        checkint("release_pulses", fall_cnt[0] - f, 1);

        // ch3 counting; reset lands mid-count and between clock edges.
        sw_raw = 4'b1110;
        step(7);
        #3;
        rst_n = 1'b0;
        #1;
        check4("rstmid_db", sw_db, 4'b0000);
        check4("rstmid_rise", rise, 4'b0000);
        check4("rstmid_fall", fall, 4'b0000);
        step(3);
        check4("rstmid_hold_db", sw_db, 4'b0000);
        rst_n = 1'b1;
        r = rise_cnt[3];
        step(9);
        check4("rstrel_pre_db", sw_db, 4'b0000);
        checkint("rstrel_pre_pulses", rise_cnt[3] - r, 0);
        step(1);
        check4("rstrel_db", sw_db, 4'b1110);
        check4("rstrel_rise", rise, 4'b1110);
        step(1);
        check4("rstrel_rise_end", rise, 4'b0000);

        // All channels step together.
        sw_raw = 4'b0000;
        step(12);
        check4("simul_clear_db", sw_db, 4'b0000);
        sw_raw = 4'b1111;
        step(9);
        check4("simul_pre_rise", rise, 4'b0000);
        step(1);
        check4("simul_rise", rise, 4'b1111);
        check4("simul_db", sw_db, 4'b1111);
        step(1);
        check4("simul_rise_end", rise, 4'b0000);
        check4("simul_db_hold", sw_db, 4'b1111);

        // ch0 toggling every cycle never gets accepted.
        f = fall_cnt[0];
        for (int k = 0; k < 30; k++) begin
            sw_raw[0] = ~sw_raw[0];
            step(1);
        end
        check4("toggle_db", sw_db, 4'b1111);
        checkint("toggle_pulses", fall_cnt[0] - f, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_switch_debounce
